// File: rtl/mem_access_ctrl.sv
// Purpose : MEM-stage data-memory access controller; turns MemRead_i/MemWrite_i into
//           a held request/ack handshake and stalls the pipeline until it finishes.
// Latency : request accepted in IDLE, >=1 ACCESS cycle, one DONE cycle (stall_o=0).
//           An access aborts after TIMEOUT ACCESS cycles without mem_ack_i.
// Backpressure: stall_o freezes PC and the IF/ID, ID/EX and EX/MEM latches from request
//           acceptance until ack/timeout. mem_req_o is held until mem_ack_i or timeout.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-low reset
//   MemRead_i, MemWrite_i      load/store present in MEM stage
//   addr_i, wdata_i            access byte address and store data
//   mem_req_o, mem_we_o        memory request and direction (1 = write)
//   mem_addr_o, mem_wdata_o    registered address/store data, stable during ACCESS
//   mem_ack_i, mem_rdata_i     one-cycle completion pulse and read data
//   rdata_o                    registered load result to MEM/WB
//   stall_o                    pipeline freeze
//   err_o                      sticky timeout flag

module mem_access_ctrl #(
    // Legal range 1..255: ACCESS cycles allowed before the access is aborted.
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // wcnt counts ACCESS cycles already spent without an ack; the cycle in
    // which it equals TO_LAST is the last one allowed.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q,  wcnt_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic        mem_op;

    assign mem_op = MemRead_i | MemWrite_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    // A simultaneous read+write is handled as a write.
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = MemWrite_i;
                    wcnt_d  = 8'd0;
                    state_d = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (mem_ack_i) begin
                    // Ack takes priority over a timeout on the same edge.
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = S_DONE;
                end else if (wcnt_q == TO_LAST) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end

            S_DONE: begin
                // The same instruction is still on MemRead_i/MemWrite_i here;
                // the pipeline advances at the end of this cycle.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_req_o   = (state_q == S_ACCESS);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

    // Gated by reset so the freeze drops in the same cycle reset is asserted,
    // even though the load/store is still present on MemRead_i/MemWrite_i.
    assign stall_o = rst_i & (((state_q == S_IDLE) & mem_op) | (state_q == S_ACCESS));

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] rdata_o;
    logic        stall_o, err_o;

    int errors = 0;
    int checks = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          req_cyc;
        int          stall_cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_req  = 1'b0;
    logic        in_txn    = 1'b0;
    logic        unstable  = 1'b0;
    int          req_cnt   = 0;
    int          stall_cnt = 0;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_we;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            // An access cut short by reset never completes; discard its entry.
            if (in_txn && exp_q.size() > 0) exp_q.delete(0);
            in_txn = 1'b0; prev_req = 1'b0; unstable = 1'b0;
            req_cnt = 0; stall_cnt = 0;
        end else begin
            if (stall_o) stall_cnt++;
            if (mem_req_o) begin
                req_cnt++;
                if (!prev_req) begin
                    in_txn = 1'b1;
                    seen_addr = mem_addr_o; seen_wdata = mem_wdata_o; seen_we = mem_we_o;
                    if (exp_q.size() == 0) begin
                        check("unexpected_request", 32'd1, 32'd0);
                    end else begin
                        check("req_addr", mem_addr_o, exp_q[0].addr);
                        check("req_we", {31'd0, mem_we_o}, {31'd0, exp_q[0].we});
                        if (exp_q[0].we) check("req_wdata", mem_wdata_o, exp_q[0].wdata);
                    end
                end else if (mem_addr_o !== seen_addr || mem_wdata_o !== seen_wdata ||
                             mem_we_o !== seen_we) begin
                    unstable = 1'b1;
                end
            end else if (prev_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_rdata", rdata_o, e.rdata);
                    check("done_err", {31'd0, err_o}, {31'd0, e.err});
                    check("req_cycles", req_cnt, e.req_cyc);
                    check("stall_cycles", stall_cnt, e.stall_cyc);
                    check("req_stable", {31'd0, unstable}, 32'd0);
                end
                in_txn = 1'b0; unstable = 1'b0;
                req_cnt = 0; stall_cnt = 0;
            end
            prev_req = mem_req_o;
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1 with the controller in IDLE. ack_n = ACCESS cycle in
    // which the memory acks (0 = never). Returns at posedge+1 back in IDLE.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_n, input logic [31:0] mrd,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_req, input int exp_stall);
        exp_t e;
        int   cyc;
        bit   done;
        e.we = wr; e.addr = addr; e.wdata = wdata; e.rdata = exp_rdata;
        e.err = exp_err; e.req_cyc = exp_req; e.stall_cyc = exp_stall;
        exp_q.push_back(e);
        MemRead_i = rd; MemWrite_i = wr; addr_i = addr; wdata_i = wdata;
        @(posedge clk_i); #1;
        cyc  = 1;
        done = 1'b0;
        while (!done) begin
            if (cyc == ack_n) begin
                mem_ack_i = 1'b1; mem_rdata_i = mrd;
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
            if (!stall_o) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (cyc > 64) begin
                    check("access_bound", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk_i); #1;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        addr_i = 32'd0; wdata_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // load, ack in 3rd ACCESS cycle
        issue(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3, 4);
        // store, ack in 1st ACCESS cycle; rdata untouched
        issue(1'b0, 1'b1, 32'h20, 32'h12345678, 1, 32'h55555555, 32'hDEADBEEF, 1'b0, 1, 2);
        // read+write together behaves as a write
        issue(1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, 1, 32'h55555555, 32'hDEADBEEF, 1'b0, 1, 2);
        // ack in the last allowed cycle wins over the timeout
        issue(1'b1, 1'b0, 32'h180, 32'h0, 4, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 4, 5);

        // stray ack in IDLE
        mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
        check("idle_ack_req", {31'd0, mem_req_o}, 32'd0);
        check("idle_ack_rdata", rdata_o, 32'hCAFEF00D);
        check("idle_ack_err", {31'd0, err_o}, 32'd0);

        // back-to-back load then store
        issue(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h11112222, 32'h11112222, 1'b0, 1, 2);
        issue(1'b0, 1'b1, 32'h204, 32'h33334444, 1, 32'h55555555, 32'h11112222, 1'b0, 1, 2);

        // timeout: no ack, 4 ACCESS cycles, read result forced to 0
        issue(1'b1, 1'b0, 32'h240, 32'h0, 0, 32'h0, 32'h0, 1'b1, 4, 5);
        // following load completes, err stays set
        issue(1'b1, 1'b0, 32'h260, 32'h0, 2, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 2, 3);

        // reset during the 2nd ACCESS cycle of a load
        begin
            exp_t e;
            e.we = 1'b0; e.addr = 32'h300; e.wdata = 32'h0; e.rdata = 32'h0;
            e.err = 1'b0; e.req_cyc = 0; e.stall_cyc = 0;
            exp_q.push_back(e);
        end
        MemRead_i = 1'b1; addr_i = 32'h300;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        check("midrst_req", {31'd0, mem_req_o}, 32'd0);
        check("midrst_stall", {31'd0, stall_o}, 32'd0);
        check("midrst_err", {31'd0, err_o}, 32'd0);
        check("midrst_rdata", rdata_o, 32'd0);
        MemRead_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
        check("postrst_ack_req", {31'd0, mem_req_o}, 32'd0);
        check("postrst_ack_stall", {31'd0, stall_o}, 32'd0);
        check("postrst_ack_rdata", rdata_o, 32'd0);
        check("postrst_ack_err", {31'd0, err_o}, 32'd0);

        // access accepted on the first edge after reset release
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        issue(1'b1, 1'b0, 32'h400, 32'h0, 1, 32'h77778888, 32'h77778888, 1'b0, 1, 2);

        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 0 && guard < 20) begin
                @(posedge clk_i);
                guard++;
            end
            if (exp_q.size() > 0) check("pending_expectations", exp_q.size(), 32'd0);
        end
        repeat (2) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum ACCESS-state cycles to wait for mem_ack_i before abort; legal range 1..255.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 MemRead_i  input  1  load in MEM stage (from EX/MEM latch).
REQ-005 MemWrite_i  input  1  store in MEM stage (from EX/MEM latch).
REQ-006 addr_i  input  32  access byte address (ALU result).
REQ-007 wdata_i  input  32  store data.
REQ-008 mem_req_o  output  1  request to data memory, held until acknowledged.
REQ-009 mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o=1.
REQ-010 mem_addr_o  output  32  registered access address.
REQ-011 mem_wdata_o  output  32  registered store data.
REQ-012 mem_ack_i  input  1  memory completion, one-cycle pulse; read data valid in the same cycle.
REQ-013 mem_rdata_i  input  32  memory read data.
REQ-014 rdata_o  output  32  registered load result to MEM/WB.
REQ-015 stall_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM while 1.
REQ-016 err_o  output  1  sticky timeout flag.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE; 8-bit wait counter wcnt.
REQ-018 IDLE: if MemRead_i|MemWrite_i = 1, latch addr_i->mem_addr_o, wdata_i->mem_wdata_o, MemWrite_i->mem_we_o, clear wcnt, next state ACCESS; otherwise remain in IDLE.
REQ-019 MemRead_i=MemWrite_i=1 simultaneously: treated as write (mem_we_o=1); rdata_o unchanged.
REQ-020 stall_o combinational: 1 when (IDLE and (MemRead_i|MemWrite_i)) or ACCESS; 0 in DONE and in an idle IDLE.
REQ-021 mem_req_o = 1 exactly while in ACCESS; mem_addr_o/mem_we_o/mem_wdata_o stable throughout ACCESS.
REQ-022 ACCESS, mem_ack_i=1: if mem_we_o=0, rdata_o <= mem_rdata_i; next state DONE; minimum access latency 1 ACCESS cycle (stall_o high for 2 cycles total).
REQ-023 ACCESS, mem_ack_i=0: wcnt increments; when wcnt reaches TIMEOUT-1 without ack, set err_o, rdata_o <= 0 if read, next state DONE.
REQ-024 Ack on the same edge as timeout: ack wins, err_o not set.
REQ-025 DONE lasts one cycle with stall_o=0 so the pipeline advances; MemRead_i/MemWrite_i ignored in DONE (same instruction still present); next state IDLE.
REQ-026 mem_ack_i in IDLE or DONE is ignored; no state or output change.
REQ-027 Back-to-back memory instructions: each costs IDLE(stall)->ACCESS(>=1)->DONE; no request is dropped.
REQ-028 err_o stays 1 until reset; subsequent accesses proceed normally.
REQ-029 rdata_o holds its value between loads; stores never alter it.

Reset
REQ-030 rst_i=0 asynchronously forces IDLE, wcnt=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, err_o=0.
REQ-031 Reset asserted mid-ACCESS drops mem_req_o immediately; an ack arriving after reset release in IDLE is ignored.
REQ-032 After rst_i rises, first access may be accepted on the first rising edge.

Verification
REQ-033 Load, ack after 3 cycles: MemRead_i=1, addr_i=0x100, mem_rdata_i=0xDEADBEEF -> mem_req_o high 3 cycles, mem_addr_o=0x100, mem_we_o=0, stall_o high 4 cycles, rdata_o=0xDEADBEEF in DONE.
REQ-034 Store, ack next cycle: MemWrite_i=1, addr_i=0x20, wdata_i=0x12345678 -> one ACCESS cycle, mem_we_o=1, mem_wdata_o=0x12345678, rdata_o unchanged.
REQ-035 Timeout, TIMEOUT=4, no ack: load -> mem_req_o high 4 cycles, then DONE with err_o=1, rdata_o=0; next load with ack works, err_o stays 1.
REQ-036 Back-to-back load then store, ack after 1 cycle each: sequence IDLE,ACCESS,DONE,IDLE,ACCESS,DONE; stall_o pattern 1,1,0,1,1,0.
REQ-037 Reset mid-ACCESS: rst_i=0 on cycle 2 of a load -> mem_req_o=0, stall_o=0 same cycle; stray ack after release produces no change.
REQ-038 Simultaneous MemRead_i=MemWrite_i=1 -> mem_we_o=1, rdata_o unchanged after ack.
